// File: rtl/mem2axi.sv
`default_nettype none
// ============================================================================
// Module   : mem2axi
// Purpose  : Bridges a simple req/gnt memory port onto a single-beat AXI
//            manager interface. Exactly one transaction is in flight at a
//            time. Writes drive AW and W in parallel and wait for B. Reads
//            drive AR and wait for R. A registered one-cycle rvalid_o pulse
//            reports completion of either kind, together with err_o and,
//            for reads, rdata_o.
// Ports    : clk_i, rst_ni            - clock, async active-low reset
//            req_i/gnt_o/we_i/addr_i/  - memory-side request port
//            be_i/wdata_i
//            rvalid_o/rdata_o/err_o    - memory-side completion
//            aw_*, w_*, b_*, ar_*, r_* - AXI channels (ID/LEN/SIZE/BURST/
//                                        WLAST are tied off by the integrator)
// Revision : 1.0 - initial release
// ============================================================================
module mem2axi #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,

  // Memory-side request port
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,

  // Memory-side completion
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,

  // AXI write address channel
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,

  // AXI write data channel
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,

  // AXI write response channel
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [1:0]                  b_resp_i,

  // AXI read address channel
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,

  // AXI read data channel
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i
);

  localparam int c_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WAIT_B = 3'd2,
    S_READ   = 3'd3,
    S_WAIT_R = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  // Captured request
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [c_STRB_WIDTH-1:0]     r_be;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;

  // Per-transaction handshake tracking for the two write request channels
  logic                        r_aw_done;
  logic                        r_w_done;

  // Completion registers
  logic                        r_rvalid;
  logic                        r_err;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;

  // Handshake strobes
  logic                        w_grant;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_b_hs;
  logic                        w_ar_hs;
  logic                        w_r_hs;

  // Only bit 1 of the response (SLVERR/DECERR) is significant.
  logic                        w_unused;
  assign w_unused = ^{b_resp_i[0], r_resp_i[0]};

  // --------------------------------------------------------------------------
  // Next-state and channel control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    gnt_o        = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    b_ready_o    = 1'b0;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // rst_ni is folded in so gnt_o is low while reset is asserted even
        // though req_i may be high.
        gnt_o = req_i & rst_ni;
        if (req_i) begin
          w_state_next = we_i ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        // Each channel drops its valid once its own handshake is done and
        // stays low for the rest of the transaction.
        aw_valid_o = ~r_aw_done;
        w_valid_o  = ~r_w_done;
        // Leave as soon as both channels have completed, whether they
        // finish together or the last one finishes this cycle.
        if ((r_aw_done | (~r_aw_done & aw_ready_i)) &&
            (r_w_done  | (~r_w_done  & w_ready_i))) begin
          w_state_next = S_WAIT_B;
        end
      end

      S_WAIT_B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          w_state_next = S_IDLE;
        end
      end

      S_READ: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          w_state_next = S_WAIT_R;
        end
      end

      S_WAIT_R: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_grant = gnt_o;
  assign w_aw_hs = aw_valid_o & aw_ready_i;
  assign w_w_hs  = w_valid_o  & w_ready_i;
  assign w_b_hs  = b_ready_o  & b_valid_i;
  assign w_ar_hs = ar_valid_o & ar_ready_i;
  assign w_r_hs  = r_ready_o  & r_valid_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and write-channel tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr    <= addr_i;
        r_be      <= be_i;
        r_wdata   <= wdata_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion: the pulse lands the cycle after B/R, when the FSM is
  // already back in IDLE and may be granting the next request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_b_hs | w_r_hs;
      if (w_b_hs) begin
        r_err <= b_resp_i[1];
      end else if (w_r_hs) begin
        r_err <= r_resp_i[1];
      end
      // Write completions leave the last read data in place.
      if (w_r_hs) begin
        r_rdata <= r_data_i;
      end
    end
  end

  // The AR handshake strobe is only needed to document the READ exit; the
  // FSM decodes ar_ready_i directly.
  logic w_unused_ar;
  assign w_unused_ar = w_ar_hs;

  // --------------------------------------------------------------------------
  // Output assignments: payloads come straight from the capture registers,
  // so they are stable for as long as the matching valid is high.
  // --------------------------------------------------------------------------
  assign aw_addr_o = r_addr;
  assign ar_addr_o = r_addr;
  assign w_data_o  = r_wdata;
  assign w_strb_o  = r_be;
  assign rvalid_o  = r_rvalid;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;

endmodule
`default_nettype wire

// File: doc/mem2axi.md
MEM2AXI -- requirements
Module: mem2axi

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width of memory port and AXI AW/AR.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; strobe/byte-enable width AXI_DATA_WIDTH/8.
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_i  input  1  memory-side request valid.
REQ-006 gnt_o  output  1  request accepted this cycle.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 addr_i  input  AXI_ADDR_WIDTH  byte address.
REQ-009 be_i  input  AXI_DATA_WIDTH/8  write byte enables.
REQ-010 wdata_i  input  AXI_DATA_WIDTH  write data.
REQ-011 rvalid_o  output  1  one-cycle completion pulse, reads and writes.
REQ-012 rdata_o  output  AXI_DATA_WIDTH  read data, valid with rvalid_o.
REQ-013 err_o  output  1  response error, valid with rvalid_o.
REQ-014 aw_valid_o  output  1; aw_ready_i  input  1; aw_addr_o  output  AXI_ADDR_WIDTH  AW channel.
REQ-015 w_valid_o  output  1; w_ready_i  input  1; w_data_o  output  AXI_DATA_WIDTH; w_strb_o  output  AXI_DATA_WIDTH/8  W channel.
REQ-016 b_valid_i  input  1; b_ready_o  output  1; b_resp_i  input  2  B channel.
REQ-017 ar_valid_o  output  1; ar_ready_i  input  1; ar_addr_o  output  AXI_ADDR_WIDTH  AR channel.
REQ-018 r_valid_i  input  1; r_ready_o  output  1; r_data_i  input  AXI_DATA_WIDTH; r_resp_i  input  2  R channel.
REQ-019 SHALL issue only single-beat transfers: integrator ties ID=0, LEN=0, SIZE=log2(AXI_DATA_WIDTH/8), BURST=INCR, WLAST=1 outside the block.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ, WAIT_R; exactly one transaction outstanding.
REQ-021 IDLE: gnt_o = req_i (combinational); gnt_o SHALL be 0 in every other state.
REQ-022 On grant SHALL register addr_i, be_i, wdata_i; next state WRITE if we_i else READ.
REQ-023 WRITE: aw_valid_o and w_valid_o both asserted in the first WRITE cycle; each SHALL deassert independently after its own valid&ready handshake (tracked by aw_done/w_done flags) and never reassert for that transaction.
REQ-024 WRITE -> WAIT_B in the cycle the last of AW/W handshakes completes, including both in the same cycle.
REQ-025 WAIT_B: b_ready_o = 1; on b_valid_i -> IDLE. b_ready_o SHALL be 0 in all other states.
REQ-026 READ: ar_valid_o = 1 until ar_ready_i; -> WAIT_R. WAIT_R: r_ready_o = 1; on r_valid_i capture r_data_i -> IDLE.
REQ-027 Valid outputs SHALL be held stable with stable payload until handshake (AXI rule); no dependency of valid on ready.
REQ-028 rvalid_o SHALL be registered: high exactly the cycle after B or R handshake, when the FSM is already IDLE; a new grant MAY coincide with that pulse.
REQ-029 err_o SHALL equal bit 1 of the captured resp (SLVERR/DECERR = 1, OKAY/EXOKAY = 0); rdata_o holds last read data until next read completes; write completions leave rdata_o unchanged.
REQ-030 Minimum latency with always-ready slave: grant at cycle 0, AW/W or AR handshake cycle 1, B/R cycle 2, rvalid_o cycle 3.
REQ-031 aw_addr_o/ar_addr_o SHALL drive the captured address unmodified (no alignment).

Reset
REQ-032 rst_ni low SHALL asynchronously force IDLE, all valid/ready/gnt/rvalid/err outputs 0, data/addr registers 0; an in-flight transaction is abandoned with no completion pulse.

Verification
REQ-033 Write 0xDEADBEEF_CAFEF00D to 0x8000_0010, be=0xFF, always-ready slave, b_resp=00 -> AW/W in cycle 1, rvalid_o cycle 3, err_o=0.
REQ-034 Read 0x8000_0010, R data 0x1122334455667788, r_resp=00 -> rdata_o=0x1122334455667788 with rvalid_o, err_o=0.
REQ-035 Write with w_ready_i delayed 3 cycles after aw_ready_i -> aw_valid_o drops after 1 cycle, w_valid_o held 4 cycles with stable data, single rvalid_o.
REQ-036 Read with r_resp=10, then write with b_resp=11 -> err_o=1 on both completions.
REQ-037 rst_ni pulsed low while in WAIT_R -> all outputs 0 immediately, no rvalid_o; next req_i granted in IDLE.
REQ-038 req_i held high continuously, alternating we_i -> exactly one gnt_o per transaction, never while non-IDLE.
